subneg_membus_ctrl: RTL and testbench

Sequences the shared external SRAM bus, which carries an 8-bit multiplexed address/data path with an external address latch (LE), output enable (MOE) and write enable (MWE). The bus has two requesters: the subneg CPU core and the host program loader/debug port. The block arbitrates between them round-robin, runs one complete read or write bus cycle per grant, and returns read data with a one-cycle ack. It sits between the core/loader and the TinyTapeout uio pins.

---
 rtl/subneg_membus_ctrl.sv | 119 +++++++++++
 tb/tb_subneg_membus_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/subneg_membus_ctrl.sv
// subneg_membus_ctrl: round-robin sequencer for the shared multiplexed SRAM bus,
// running one full read or write cycle per grant for the subneg core or the host loader.
module subneg_membus_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_wdata,
    output logic       ld_ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       owner,
    output logic [7:0] bus_out,
    output logic [7:0] bus_oe,
    input  logic [7:0] bus_in,
    output logic       le,
    output logic       moe,
    output logic       mwe
);
    typedef enum logic [2:0] {IDLE, ADDR, LATCH, RD, WDATA, WSTB, WHOLD, DONE} state_t;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    state_t     state;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [3:0] cnt;
    logic       pick_ld;
    // on contention the previous owner yields
    assign pick_ld = ld_req && (!cpu_req || !owner);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cnt     <= 4'd0;
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            rdata   <= 8'h00;
            busy    <= 1'b0;
            owner   <= 1'b1;
            bus_out <= 8'h00;
            bus_oe  <= 8'h00;
            le      <= 1'b0;
            moe     <= 1'b0;
            mwe     <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state)
                IDLE: if (cpu_req || ld_req) begin
                    state   <= ADDR;
                    owner   <= pick_ld;
                    we_q    <= pick_ld ? ld_we : cpu_we;
                    addr_q  <= pick_ld ? ld_addr : cpu_addr;
                    wdata_q <= pick_ld ? ld_wdata : cpu_wdata;
                    bus_out <= pick_ld ? ld_addr : cpu_addr;
                    bus_oe  <= 8'hFF;
                    le      <= 1'b1;
                    busy    <= 1'b1;
                end
                ADDR: begin
                    state <= LATCH;
                    le    <= 1'b0;
                end
                LATCH: if (!we_q) begin
                    state  <= RD;
                    bus_oe <= 8'h00;
                    moe    <= 1'b1;
                    cnt    <= WAIT_LOAD;
                end else begin
                    state   <= WDATA;
                    bus_out <= wdata_q;
                end
                RD: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state   <= DONE;
                    rdata   <= bus_in;
                    moe     <= 1'b0;
                    bus_out <= 8'h00;
                    cpu_ack <= !owner;
                    ld_ack  <= owner;
                end
                WDATA: begin
                    state <= WSTB;
                    mwe   <= 1'b1;
                    cnt   <= WAIT_LOAD;
                end
                WSTB: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state <= WHOLD;
                    mwe   <= 1'b0;
                end
                WHOLD: begin
                    state   <= DONE;
                    bus_oe  <= 8'h00;
                    bus_out <= 8'h00;
                    cpu_ack <= !owner;
                    ld_ack  <= owner;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    wire unused_addr = ^addr_q;
endmodule

// File: tb/tb_subneg_membus_ctrl.sv
// tb_subneg_membus_ctrl: directed bench with an SRAM/latch model and an ack-driven scoreboard.
module tb_subneg_membus_ctrl;
    localparam int W = 2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, ld_req, ld_we;
    logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic       cpu_ack, ld_ack, busy, owner, le, moe, mwe;
    logic [7:0] rdata, bus_out, bus_oe, bus_in;
    logic [7:0] mem [256];
    logic [7:0] lat_a = 8'h00;
    typedef struct {
        logic       ld;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    int cyc = 0, grant_cyc = 0, ack_cyc = 0, prev_ack = 0;
    int le_cnt = 0, moe_cnt = 0, mwe_cnt = 0;
    logic [7:0] seen_addr = 8'h00;
    logic busy_prev = 1'b0;

    subneg_membus_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .rdata(rdata), .busy(busy), .owner(owner),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .le(le), .moe(moe), .mwe(mwe)
    );

    always #5 clk = ~clk;

    // external address latch plus SRAM; bus reads back a marker when MOE is low
    always @(posedge clk) begin
        if (le) lat_a <= bus_out;
        if (mwe) mem[lat_a] <= bus_out;
    end
    assign bus_in = moe ? mem[lat_a] : 8'hEE;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        mem[8'h12] <= 8'hA5;
        mem[8'h10] <= 8'h77;
        mem[8'h20] <= 8'h88;
        mem[8'h30] <= 8'hC3;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic ld, input logic we, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.ld = ld; e.we = we; e.addr = addr; e.data = data; e.lat = we ? 5 + W : 3 + W;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit ld);
        int n = 0;
        while (n < 60) begin
            @(negedge clk); #1;
            if (ld ? ld_ack : cpu_ack) break;
            n++;
        end
        if (n >= 60) check(ld ? "ld_ack_timeout" : "cpu_ack_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) busy_prev = 1'b0;
        else begin
            check("bus_inv", 32'({le && moe || le && mwe || moe && mwe, moe && bus_oe != 8'h00,
                                  mwe && bus_oe != 8'hFF, bus_oe != 8'h00 && bus_oe != 8'hFF}), 0);
            if (busy && !busy_prev) begin
                grant_cyc = cyc; le_cnt = 0; moe_cnt = 0; mwe_cnt = 0;
            end
            busy_prev = busy;
            if (le) begin le_cnt++; seen_addr = bus_out; end
            if (moe) moe_cnt++;
            if (mwe) begin
                mwe_cnt++;
                if (sb.size() > 0) check("wstb_data", 32'(bus_out), 32'(sb[0].data));
            end
            if (cpu_ack || ld_ack) begin
                if (sb.size() == 0) check("unexpected_ack", 32'({cpu_ack, ld_ack}), 0);
                else begin
                    e = sb.pop_front();
                    check("ack_who", 32'({cpu_ack, ld_ack}), e.ld ? 32'd1 : 32'd2);
                    check("owner", 32'(owner), 32'(e.ld));
                    check("latency", 32'(cyc - grant_cyc + 1), 32'(e.lat));
                    check("bus_addr", 32'(seen_addr), 32'(e.addr));
                    check("le_cycles", 32'(le_cnt), 1);
                    check("moe_cycles", 32'(moe_cnt), e.we ? 0 : W);
                    check("mwe_cycles", 32'(mwe_cnt), e.we ? W : 0);
                    if (e.we) check("mem_write", 32'(mem[e.addr]), 32'(e.data));
                    else check("rdata", 32'(rdata), 32'(e.data));
                end
                ack_cyc = cyc;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", 32'({le, moe, mwe, busy, cpu_ack, ld_ack}), 0);
        check("rst_owner", 32'(owner), 1);
        check("rst_bus", 32'({bus_out, bus_oe, rdata}), 0);
        rst_n = 1'b1;
        // CPU read
        @(posedge clk); #1;
        push(0, 0, 8'h12, 8'hA5);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
        wait_ack(0);
        @(posedge clk); #1;
        cpu_req = 0;
        // loader write
        push(1, 1, 8'h40, 8'h3C);
        ld_req = 1; ld_we = 1; ld_addr = 8'h40; ld_wdata = 8'h3C;
        wait_ack(1);
        @(posedge clk); #1;
        ld_req = 0;
        // simultaneous requests after a loader grant: CPU first
        @(posedge clk); #1;
        push(0, 0, 8'h40, 8'h3C);
        push(1, 0, 8'h12, 8'hA5);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
        ld_req = 1; ld_we = 0; ld_addr = 8'h12;
        wait_ack(0);
        @(posedge clk); #1;
        cpu_req = 0;
        wait_ack(1);
        @(posedge clk); #1;
        ld_req = 0;
        // address changes after the grant edge
        push(0, 0, 8'h10, 8'h77);
        cpu_req = 1; cpu_addr = 8'h10;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        cpu_addr = 8'h20;
        wait_ack(0);
        @(posedge clk); #1;
        cpu_req = 0;
        // reset mid write strobe
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h50; cpu_wdata = 8'h99;
        for (int n = 0; n < 30 && !mwe; n++) @(negedge clk);
        check("abort_reached_wstb", 32'(mwe), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_ctrl", 32'({le, moe, mwe, busy, cpu_ack, ld_ack}), 0);
        check("abort_async_oe", 32'(bus_oe), 0);
        cpu_req = 0; cpu_we = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_owner", 32'(owner), 1);
        check("abort_no_pending", 32'(sb.size()), 0);
        // contention right after reset goes to the CPU
        @(posedge clk); #1;
        push(0, 0, 8'h30, 8'hC3);
        push(1, 0, 8'h31, 8'h6B);
        cpu_req = 1; cpu_addr = 8'h30;
        ld_req = 1; ld_we = 0; ld_addr = 8'h31;
        wait_ack(0);
        @(posedge clk); #1;
        cpu_req = 0;
        wait_ack(1);
        @(posedge clk); #1;
        ld_req = 0;
        // back-to-back reads with req held high
        push(0, 0, 8'h00, 8'h5A);
        push(0, 0, 8'h01, 8'h5B);
        push(0, 0, 8'hFF, 8'hA5);
        cpu_req = 1; cpu_addr = 8'h00;
        wait_ack(0);
        prev_ack = ack_cyc;
        @(posedge clk); #1;
        cpu_addr = 8'h01;
        wait_ack(0);
        check("b2b_gap1", 32'(grant_cyc - prev_ack), 2);
        prev_ack = ack_cyc;
        @(posedge clk); #1;
        cpu_addr = 8'hFF;
        wait_ack(0);
        check("b2b_gap2", 32'(grant_cyc - prev_ack), 2);
        @(posedge clk); #1;
        cpu_req = 0;
        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);
        check("final_busy", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
